dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//   Shares the single data memory between two requesters (port 0: core load/store,
//   port 1: refill/DMA engine) and sequences each access. Serialises word writes and
//   128-bit line reads, holds mr for the memory's fixed read latency, and returns
//   the captured line with a one-cycle ack. Sits between requesters and DataMem.
// PARAMETERS
//   ADDR_W    32   address width, passed unchanged to memory A
//   DATA_W    32   write word width (memory D)
//   LINE_W    128  read line width (memory O)
//   READ_LAT  3    cycles mem_mr is held before mem_rdata is captured (>=1)
// PORTS
//   clk         in   1        clock, all state on posedge
//   rst         in   1        asynchronous, active-high reset
//   r0_req      in   1        port 0 request; held with r0_we/addr/wdata until r0_ack
//   r0_we       in   1        1 = write word, 0 = read line
//   r0_addr     in   ADDR_W   access address
//   r0_wdata    in   DATA_W   write data
//   r0_ack      out  1        one-cycle completion pulse
//   r0_rdata    out  LINE_W   last line read for port 0 (registered)
//   r1_*        --   --       identical set for port 1
//   mem_addr    out  ADDR_W   to memory A
//   mem_wdata   out  DATA_W   to memory D
//   mem_mr      out  1        to memory mr
//   mem_mw      out  1        to memory mw
//   mem_rdata   in   LINE_W   from memory O
//   busy        out  1        1 whenever state != IDLE
// BEHAVIOUR
//   Reset (async, any time, incl. mid-access): state=IDLE, mem_mr=mem_mw=0,
//     mem_addr=mem_wdata=0, r0/r1_ack=0, r0/r1_rdata=0, last_grant=1, lat_cnt=0.
//     Aborted access is dropped; no ack is ever issued for it.
//   States: IDLE, WR, RD, RESP. All outputs are registered or decoded from state only.
//   IDLE: if any req, grant, latch sel/we/addr/wdata -> WR (we=1) or RD (we=0); else stay.
//   Arbitration: one req -> grant it. Both -> grant port != last_grant (round robin);
//     last_grant updated on grant. After reset port 0 wins a tie.
//   WR: mem_mw=1 for exactly one cycle, mem_addr/mem_wdata = latched values -> RESP.
//   RD: mem_mr=1, mem_addr latched; lat_cnt counts 0..READ_LAT-1; on last RD cycle
//     mem_rdata is captured into rdata of the granted port only -> RESP.
//   RESP: ack of granted port =1 for this one cycle, strobes 0 -> IDLE.
//   Latency (req seen high at edge N): write ack high in cycle N+2; read ack high in
//     cycle N+READ_LAT+1; rdata valid with ack and held until that port's next read.
//   Requester must drop req in the cycle after ack; req still high in IDLE = new access.
//   Req dropped mid-access: access still completes and ack still pulses.
//   Non-granted port's req is ignored until IDLE; ungranted rdata never changes.
//   mem_mr and mem_mw are never high in the same cycle; at most one ack high per cycle.
//   Minimum gap between accesses: one IDLE cycle after every RESP.
// STRUCTURE
//   dmem_defs.vh: state encoding localparams (IDLE/WR/RD/RESP), default widths, READ_LAT.
//   Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], last_grant, update -> gnt[1:0]).
//   Top holds FSM, latency counter, request latch, per-port rdata registers.
// TESTING
//   Reset mid-RD (r0 read in flight, rst pulse) -> mem_mr=0 same cycle, no r0_ack,
//     r0_rdata=0, next tie goes to port 0.
//   r0 write addr=0x10 data=0xDEADBEEF -> mem_mw=1 one cycle with those values, r0_ack
//     at N+2, r1_ack never asserts, r0_rdata unchanged.
//   r1 read addr=0x40, mem model returns 128'h0123_4567_89AB_CDEF_... -> mem_mr held
//     3 cycles, r1_rdata equals model line, r1_ack at N+4.
//   Both req continuously (reads) for 4 grants -> grants 0,1,0,1; acks never overlap;
//     each port's rdata only updated on its own ack.
//   READ_LAT=1 build: back-to-back r0 reads -> ack every 3 cycles, one IDLE between.
//   r0 drops req one cycle after grant on a write -> mw still pulses, r0_ack still pulses.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: state encoding,
// default widths and read latency, and a counter-width helper.
package dmem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_LINE_W   = 128;
  localparam int unsigned DEF_READ_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational: the caller owns the
// last-grant register. Grants are only issued while i_update is high.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

  // Pick a winner: a lone requester wins; on a tie the port that did not win last time.
  always_comb begin
    o_gnt = 2'b00;
    if (i_update) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end else begin
      o_gnt = 2'b00;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data memory between a core port (0) and a refill/DMA port (1).
// Word writes take one memory cycle, line reads hold mem_mr for READ_LAT
// cycles; each access ends with a one-cycle ack and returns to IDLE.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LINE_W   = DEF_LINE_W,
  parameter int unsigned READ_LAT = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [LINE_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [LINE_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_mr,
  output logic              mem_mw,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W = cnt_width(READ_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_last_grant;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [LINE_W-1:0] r_rdata0;
  logic [LINE_W-1:0] r_rdata1;
  logic [1:0]        w_gnt;
  logic              w_start;
  logic              w_gnt_we;
  logic              w_lat_done;

  rr_arb2 u_arb (
    .i_req        ({r1_req, r0_req}),
    .i_last_grant (r_last_grant),
    .i_update     (r_state == ST_IDLE),
    .o_gnt        (w_gnt)
  );

  assign w_start    = |w_gnt;
  assign w_gnt_we   = w_gnt[1] ? r1_we : r0_we;
  assign w_lat_done = (r_lat_cnt == LAT_W'(READ_LAT - 1));

  // Next-state decode for the access sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = w_gnt_we ? ST_WR : ST_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR:   w_state_nxt = ST_RESP;
      ST_RD: begin
        if (w_lat_done) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_RD;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winning request and remember who won for the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_last_grant <= 1'b1;
    end else if (w_start) begin
      r_sel        <= w_gnt[1];
      r_addr       <= w_gnt[1] ? r1_addr : r0_addr;
      r_wdata      <= w_gnt[1] ? r1_wdata : r0_wdata;
      r_last_grant <= w_gnt[1];
    end
  end

  // Count read cycles; cleared whenever the sequencer is not mid-read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_cnt <= '0;
    end else if ((r_state == ST_RD) && !w_lat_done) begin
      r_lat_cnt <= r_lat_cnt + LAT_W'(1);
    end else begin
      r_lat_cnt <= '0;
    end
  end

  // Capture the returned line into the granted port's register on the last read cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if ((r_state == ST_RD) && w_lat_done) begin
      if (r_sel) begin
        r_rdata1 <= mem_rdata;
      end else begin
        r_rdata0 <= mem_rdata;
      end
    end
  end

  assign mem_mw    = (r_state == ST_WR);
  assign mem_mr    = (r_state == ST_RD);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign r0_ack    = (r_state == ST_RESP) && !r_sel;
  assign r1_ack    = (r_state == ST_RESP) && r_sel;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;
  assign busy      = (r_state != ST_IDLE);

endmodule
